// File: rtl/approx_qor_monitor.sv
// Windowed quality-of-result monitor for an approximate partition.
// Accumulates error count, error-distance sum/max and Hamming-distance sum, then reports once per window.
module approx_qor_monitor #(
   parameter int W      = 5,
   parameter int WINDOW = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [W-1:0]               approx,
   input  logic [W-1:0]               exact,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [15:0]                err_cnt,
   output logic [W+15:0]              ed_sum,
   output logic [W-1:0]               ed_max,
   output logic [16+$clog2(W+1)-1:0]  hd_sum,
   output logic [15:0]                samples
);

   // state  | meaning
   // ACCUM  | accepting samples, accumulating the current window
   // REPORT | window complete, record held until res_ready

   localparam int HDW = $clog2(W + 1);
   localparam int HSW = 16 + HDW;

   typedef enum logic {
      ACCUM  = 1'b0,
      REPORT = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [W-1:0]   ed;
   logic [HDW-1:0] hd;
   logic           accept;
   logic           last_sample;
   logic           handshake;

   logic [15:0]    err_cnt_q;
   logic [W+15:0]  ed_sum_q;
   logic [W-1:0]   ed_max_q;
   logic [HSW-1:0] hd_sum_q;
   logic [15:0]    samples_q;

   function automatic logic [HDW-1:0] popcount(input logic [W-1:0] v);
      logic [HDW-1:0] c;
      c = '0;
      for (int i = 0; i < W; i++) begin
         c = c + HDW'(v[i]);
      end
      return c;
   endfunction

   always_comb begin
      ed = '0;
      if (exact >= approx) begin
         ed = exact - approx;
      end else begin
         ed = approx - exact;
      end
      hd = popcount(exact ^ approx);
   end

   // Handshake flags come straight from the state register, so no input reaches them combinationally.
   always_comb begin
      in_ready  = (state_q == ACCUM);
      res_valid = (state_q == REPORT);
   end

   assign accept      = in_valid && in_ready;
   assign handshake   = res_valid && res_ready;
   assign last_sample = (samples_q == 16'(WINDOW - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ACCUM;
      end else begin
         case (state_q)
            ACCUM: begin
               if (accept && last_sample) begin
                  state_d = REPORT;
               end
            end
            REPORT: begin
               if (res_ready) begin
                  state_d = ACCUM;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   // Consuming a record and aborting both restart the window from zero.
   always_ff @(posedge clk) begin
      if (rst || clear || handshake) begin
         err_cnt_q <= '0;
         ed_sum_q  <= '0;
         ed_max_q  <= '0;
         hd_sum_q  <= '0;
         samples_q <= '0;
      end else if (accept) begin
         err_cnt_q <= err_cnt_q + 16'(ed != '0);
         ed_sum_q  <= ed_sum_q + (W+16)'(ed);
         hd_sum_q  <= hd_sum_q + HSW'(hd);
         samples_q <= samples_q + 16'd1;
         if (ed > ed_max_q) begin
            ed_max_q <= ed;
         end
      end
   end

   assign err_cnt = err_cnt_q;
   assign ed_sum  = ed_sum_q;
   assign ed_max  = ed_max_q;
   assign hd_sum  = hd_sum_q;
   assign samples = samples_q;

endmodule

// File: tb/tb_approx_qor_monitor.sv
// Scoreboard bench for approx_qor_monitor (W=5, WINDOW=4): directed scenarios plus random traffic
// against a window-list reference model.
module tb_approx_qor_monitor;

   localparam int W      = 5;
   localparam int WINDOW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  approx = '0;
   logic [W-1:0]  exact = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [15:0]   err_cnt;
   logic [W+15:0] ed_sum;
   logic [W-1:0]  ed_max;
   logic [18:0]   hd_sum;
   logic [15:0]   samples;

   approx_qor_monitor #(.W(W), .WINDOW(WINDOW)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .approx(approx), .exact(exact),
      .res_valid(res_valid), .res_ready(res_ready),
      .err_cnt(err_cnt), .ed_sum(ed_sum), .ed_max(ed_max), .hd_sum(hd_sum),
      .samples(samples)
   );

   always #5 clk = ~clk;

   typedef struct { int a; int e; } pair_t;
   typedef struct { int err; int eds; int edm; int hds; } rec_t;

   pair_t win[$];
   rec_t  exp_q[$];
   rec_t  pend;
   bit    busy = 1'b0;
   int    n_checks = 0;
   int    n_fail = 0;

   task automatic chk(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   function automatic rec_t stats();
      rec_t r;
      r = '{0, 0, 0, 0};
      foreach (win[i]) begin
         int d;
         d = (win[i].e > win[i].a) ? win[i].e - win[i].a : win[i].a - win[i].e;
         if (d != 0) r.err++;
         r.eds += d;
         if (d > r.edm) r.edm = d;
         r.hds += $countones(win[i].e ^ win[i].a);
      end
      return r;
   endfunction

   // One clock: check what the DUT shows now, drive the next inputs, advance the model, step.
   task automatic cyc(input bit iv, input int a, input int e, input bit rr, input bit clr, input bit rs);
      rec_t s;
      s = busy ? pend : stats();
      chk("in_ready", int'(in_ready), int'(!busy));
      chk("res_valid", int'(res_valid), int'(busy));
      chk("samples", int'(samples), busy ? WINDOW : win.size());
      chk("err_cnt", int'(err_cnt), s.err);
      chk("ed_sum", int'(ed_sum), s.eds);
      chk("ed_max", int'(ed_max), s.edm);
      chk("hd_sum", int'(hd_sum), s.hds);

      rst       = rs;
      clear     = clr;
      in_valid  = iv;
      approx    = W'(a);
      exact     = W'(e);
      res_ready = rr;

      if (rs || clr) begin
         win.delete();
         if (busy) begin
            busy = 1'b0;
            void'(exp_q.pop_front());
         end
      end else if (busy) begin
         if (rr) busy = 1'b0;
      end else if (iv) begin
         win.push_back('{a, e});
         if (win.size() == WINDOW) begin
            pend = stats();
            exp_q.push_back(pend);
            win.delete();
            busy = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int a, input int e, input bit rr);
      cyc(1'b1, a, e, rr, 1'b0, 1'b0);
   endtask

   task automatic idle(input bit rr);
      cyc(1'b0, 0, 0, rr, 1'b0, 1'b0);
   endtask

   // Monitor: every presented record must match the scoreboard head; it retires on handshake.
   always @(negedge clk) begin
      if (!rst && !clear && res_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_record", 1, 0);
         end else begin
            chk("rec_err_cnt", int'(err_cnt), exp_q[0].err);
            chk("rec_ed_sum", int'(ed_sum), exp_q[0].eds);
            chk("rec_ed_max", int'(ed_max), exp_q[0].edm);
            chk("rec_hd_sum", int'(hd_sum), exp_q[0].hds);
            if (res_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      int pat[7];
      pat = '{1, 0, 0, 1, 0, 1, 1};

      repeat (2) @(posedge clk);
      #1;

      // exact match
      repeat (4) send(11, 11, 1'b1);
      idle(1'b1);

      // mixed errors
      send(3, 1, 1'b1); send(0, 31, 1'b1); send(12, 12, 1'b1); send(16, 17, 1'b1);
      idle(1'b1);

      // back-pressure with offered samples during the wait
      send(3, 1, 1'b0); send(0, 31, 1'b0); send(12, 12, 1'b0); send(16, 17, 1'b0);
      repeat (5) send($urandom_range(0, 31), $urandom_range(0, 31), 1'b0);
      send(9, 2, 1'b1);
      repeat (4) send(1, 0, 1'b1);
      idle(1'b1);

      // clear mid-window, colliding sample discarded
      send(0, 31, 1'b1); send(0, 31, 1'b1);
      cyc(1'b1, 0, 31, 1'b1, 1'b1, 1'b0);
      repeat (4) send(2, 0, 1'b1);
      idle(1'b1);

      // gapped input
      foreach (pat[i]) cyc(pat[i] != 0, 7, 0, 1'b1, 1'b0, 1'b0);
      idle(1'b1);

      // clear during REPORT discards the record even with res_ready high
      repeat (4) send(5, 1, 1'b0);
      idle(1'b0);
      cyc(1'b1, 4, 4, 1'b1, 1'b1, 1'b0);
      idle(1'b1);

      // reset mid-window
      send(6, 2, 1'b1); send(6, 3, 1'b1);
      cyc(1'b1, 6, 2, 1'b1, 1'b0, 1'b1);
      repeat (4) send(0, 1, 1'b1);
      idle(1'b1);

      // random traffic
      repeat (400) begin
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, 1'b0);
      end
      repeat (3) idle(1'b1);

      chk("records_pending", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/approx_qor_monitor.md
# approx_qor_monitor

Streaming quality-of-result monitor placed directly downstream of an approximate partition such as the 5-output mult16 sub-circuit. Each cycle it can accept one pair: the approximate partition output word and the exact reference word for the same input vector. Over a fixed window of samples it accumulates error statistics:
- error count
- sum of error distance
- maximum error distance
- sum of Hamming distance

At the end of each window it presents one result record through a valid/ready handshake. The synthesis flow and the board bench use it to score candidate factorizations (k values) in hardware.

## Interface
Parameters:
- W, 5, width of the approximate and exact output words.
- WINDOW, 1024, number of samples per report; legal range 1 to 65535.

Ports (clock and reset first):
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort. Drops the current window and any pending report.
- in_valid  input  1  sample present.
- in_ready  output  1  monitor can accept a sample.
- approx  input  W  approximate partition output (po4..po0 packed, po0 = LSB).
- exact  input  W  exact reference output, same packing.
- res_valid  output  1  result record is valid.
- res_ready  input  1  consumer accepts the record.
- err_cnt  output  16  number of samples in the window with approx != exact.
- ed_sum  output  W+16  sum of |exact − approx| over the window, unsigned.
- ed_max  output  W  largest |exact − approx| in the window.
- hd_sum  output  16+$clog2(W+1)  sum of popcount(exact ^ approx) over the window.
- samples  output  16  number of samples accepted in the current window (live counter).

## Operation
States: ACCUM, REPORT.

ACCUM:
- in_ready = 1 and res_valid = 0.
- On an accept (in_valid & in_ready):
  - ed = |exact − approx|, computed as an unsigned difference of W-bit values with the result in W bits.
  - hd = popcount(exact ^ approx).
  - ed_sum += ed and hd_sum += hd.
  - err_cnt += (ed != 0).
  - ed_max = max(ed_max, ed).
  - samples += 1.
- Accepting the sample that brings samples to WINDOW moves the state to REPORT. That sample's contribution is included in the report.

REPORT:
- in_ready = 0 and res_valid = 1.
- err_cnt, ed_sum, ed_max and hd_sum hold the final window values and stay stable until the handshake.
- samples holds WINDOW.
- On res_valid & res_ready:
  - Return to ACCUM.
  - All accumulators and samples clear to 0 on the same edge.
  - The next sample can be accepted on the following cycle.

Width rules:
- The accumulator widths above cannot overflow for WINDOW ≤ 65535.
- No saturation logic is needed.

Priority, highest first: rst, then clear, then handshakes. An accept in the same cycle as clear is discarded.

Boundary conditions:
- WINDOW = 1: every accepted sample produces a report.
- in_valid low in ACCUM: state and accumulators hold.
- res_ready may be high before res_valid rises. A report is consumed only in a cycle where both are high.
- clear during REPORT: the pending record is discarded without a handshake, and the state becomes ACCUM with zeroed counters.
- rst mid-window: same effect as clear.

## Timing
- Reset values: state ACCUM, in_ready 1, res_valid 0, and err_cnt, ed_sum, ed_max, hd_sum and samples all 0.
- in_ready and res_valid are decoded directly from the state register and are registered. There is no combinational path from in_valid or res_ready to either.
- Accumulator update latency: 1 cycle. Outputs reflect a sample on the cycle after its accept.
- Window end: res_valid rises on the cycle after the WINDOW-th accept.
- Throughput:
  - One sample per cycle inside a window.
  - One dead input cycle per window when res_ready is already high (the REPORT cycle).
  - More dead cycles under consumer back-pressure.
- All results are register outputs. There is no input-to-output combinational path.

## Test plan
Bench uses W = 5 and WINDOW = 4.

1. **Reset state:** assert rst for 2 cycles → in_ready = 1, res_valid = 0, all counters 0.
2. **Exact match:** 4 samples with approx = exact = 5'h0B on consecutive cycles, res_ready = 1 → res_valid pulses 1 cycle after the 4th accept with err_cnt = 0, ed_sum = 0, ed_max = 0, hd_sum = 0.
3. **Mixed errors:** (approx, exact) pairs in order (3,1), (0,31), (12,12), (16,17) → err_cnt = 3, ed_sum = 2+31+0+1 = 34, ed_max = 31, hd_sum = 1+5+0+1 = 7.
4. **Back-pressure:** repeat scenario 3 with res_ready = 0 for 5 cycles after res_valid rises → in_ready stays 0, outputs stay stable, and in_valid samples offered during the wait are not counted. After res_ready = 1 the next window starts from zero and a further 4 samples (1,0)×4 report err_cnt = 4, ed_sum = 4, ed_max = 1, hd_sum = 4.
5. **Clear mid-window:** accept 2 samples (0,31), then assert clear together with a valid sample (0,31) → that sample is ignored and samples = 0. The next 4 accepts of (2,0) report err_cnt = 4, ed_sum = 8, ed_max = 2, hd_sum = 4.
6. **Gapped input:** in_valid toggling 1,0,0,1,0,1,1 with pairs (7,0) → report after the 4th accept only: err_cnt = 4, ed_sum = 28, ed_max = 7, hd_sum = 12, and samples increments only on accept cycles.
